fb_update_scheduler: RTL and testbench

Sequences every framebuffer rebuild between the zoom/algorithm selector and the ROM→ALU→RAM copy datapath. On power-up, a zoom/algorithm change or a refresh pulse, it clears the 640x480 framebuffer and restarts the ALU with latched configuration. It then owns the RAM write port, passing ALU writes through and gating them otherwise. It sits between the button module, the ALU and the dual-port framebuffer write side, in the 25 MHz domain.

---
 rtl/fb_sched_pkg.sv | 42 ++++
 rtl/fb_update_scheduler_if.sv | 53 +++++
 rtl/fb_clear_engine.sv | 48 ++++
 rtl/fb_update_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_fb_update_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_sched_pkg
//  Description : Shared types and constants for the framebuffer update
//                scheduler: sequencer state encoding, zoom codes, screen
//                geometry and the default clear colour.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_sched_pkg;

  typedef enum logic [2:0] {
    S_LATCH = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_COPY  = 3'd3,
    S_DONE  = 3'd4,
    S_IDLE  = 3'd5
  } state_e;

  localparam logic [2:0] ZOOM_1X      = 3'b000;
  localparam logic [2:0] ZOOM_2X      = 3'b001;
  localparam logic [2:0] ZOOM_4X      = 3'b010;
  localparam logic [2:0] ZOOM_HALF    = 3'b011;
  localparam logic [2:0] ZOOM_QUARTER = 3'b100;

  localparam int FB_W = 640;
  localparam int FB_H = 480;
  localparam int FB_PIXELS_DEFAULT = FB_W * FB_H;

  localparam logic [7:0] CLEAR_COLOR_DEFAULT = 8'h00;

  // True when the requested configuration differs from the one the ALU
  // is currently running with; used level-sensitively, not edge-detected.
  function automatic logic cfg_differs(input logic [2:0] zoom_req,
                                       input logic [3:0] alg_req,
                                       input logic [2:0] zoom_cur,
                                       input logic [3:0] alg_cur);
    return {zoom_req, alg_req} != {zoom_cur, alg_cur};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_update_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_update_scheduler_if
//  Description : Bundles the selector requests, the ALU control/write side
//                and the framebuffer write port of the update scheduler.
//                slave  : scheduler side (requests/ALU in, RAM/ALU ctrl out)
//                master : environment side (drives requests and ALU writes)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fb_update_scheduler_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  // selector requests
  logic [2:0]        zoom_req;
  logic [3:0]        alg_req;
  logic              refresh;
  // ALU status and write stream
  logic              alu_done;
  logic [ADDR_W-1:0] alu_wraddr;
  logic [DATA_W-1:0] alu_wrdata;
  logic              alu_wren;
  // ALU control
  logic              alu_reset;
  logic [2:0]        alu_zoom;
  logic [3:0]        alu_alg;
  // framebuffer write port
  logic [ADDR_W-1:0] ram_wraddr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  // status
  logic              busy;
  logic              timeout_err;
  logic [7:0]        update_count;

  modport slave (
    input  zoom_req, alg_req, refresh,
    input  alu_done, alu_wraddr, alu_wrdata, alu_wren,
    output alu_reset, alu_zoom, alu_alg,
    output ram_wraddr, ram_data, ram_wren,
    output busy, timeout_err, update_count
  );

  modport master (
    output zoom_req, alg_req, refresh,
    output alu_done, alu_wraddr, alu_wrdata, alu_wren,
    input  alu_reset, alu_zoom, alu_alg,
    input  ram_wraddr, ram_data, ram_wren,
    input  busy, timeout_err, update_count
  );

endinterface
`default_nettype wire

// File: rtl/fb_clear_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fb_clear_engine
//  Description : Address generator for the framebuffer clear sweep.
//                Ports: clock/reset; start_i reloads address 0; en_i steps
//                the address; addr_o is the current clear address; last_o
//                flags the final pixel (FB_PIXELS-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_clear_engine #(
  parameter int ADDR_W    = 19,
  parameter int FB_PIXELS = 307200
) (
  input  wire              clock,
  input  wire              reset,
  input  wire              start_i,
  input  wire              en_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic             last_o
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (start_i) begin
      addr_d = '0;
    end else if (en_i) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == c_LAST_ADDR);

endmodule
`default_nettype wire

// File: rtl/fb_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fb_update_scheduler
//  Description : Sequences each framebuffer rebuild: latch the requested
//                zoom/algorithm, clear the framebuffer, pulse the ALU reset,
//                then pass ALU writes through to the RAM until the ALU
//                reports done (or a timeout expires).
//                Ports: clock, reset (async, active-high) and the
//                fb_update_scheduler_if slave modport carrying requests,
//                ALU control/writes, the RAM write port and status.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_update_scheduler
  import fb_sched_pkg::*;
#(
  parameter int          ADDR_W         = 19,
  parameter int          DATA_W         = 8,
  parameter int          FB_PIXELS      = 307200,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = DATA_W'(CLEAR_COLOR_DEFAULT),
  parameter int          START_CYCLES   = 2,
  parameter int          TIMEOUT_CYCLES = 1048576
) (
  input wire                    clock,
  input wire                    reset,
  fb_update_scheduler_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] c_START_LAST = TW'(START_CYCLES - 1);
  localparam logic [TW-1:0] c_TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      zoom_q, zoom_d;
  logic [3:0]      alg_q, alg_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;    // START pulse length, then COPY cycles
  logic            terr_q, terr_d;
  logic            run_to_q, run_to_d; // this run ended by timeout
  logic            pend_q, pend_d;     // refresh seen while not IDLE
  logic [7:0]      ucnt_q, ucnt_d;

  logic              clr_start;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_last;

  logic              alu_reset;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic              cfg_change;

  fb_clear_engine #(
    .ADDR_W    (ADDR_W),
    .FB_PIXELS (FB_PIXELS)
  ) u_clear (
    .clock   (clock),
    .reset   (reset),
    .start_i (clr_start),
    .en_i    (clr_en),
    .addr_o  (clr_addr),
    .last_o  (clr_last)
  );

  assign cfg_change = cfg_differs(bus.zoom_req, bus.alg_req, zoom_q, alg_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_LATCH;
      zoom_q   <= '0;
      alg_q    <= '0;
      tcnt_q   <= '0;
      terr_q   <= 1'b0;
      run_to_q <= 1'b0;
      pend_q   <= 1'b0;
      ucnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      zoom_q   <= zoom_d;
      alg_q    <= alg_d;
      tcnt_q   <= tcnt_d;
      terr_q   <= terr_d;
      run_to_q <= run_to_d;
      pend_q   <= pend_d;
      ucnt_q   <= ucnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    zoom_d     = zoom_q;
    alg_d      = alg_q;
    tcnt_d     = tcnt_q;
    terr_d     = terr_q;
    run_to_d   = run_to_q;
    pend_d     = pend_q;
    ucnt_d     = ucnt_q;
    clr_start  = 1'b0;
    clr_en     = 1'b0;
    alu_reset  = 1'b0;
    ram_wraddr = '0;
    ram_data   = '0;
    ram_wren   = 1'b0;

    // IDLE acts on refresh directly; LATCH is already starting a fresh
    // rebuild, so a pulse there is absorbed.
    if (bus.refresh && state_q != S_IDLE && state_q != S_LATCH) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_LATCH: begin
        alu_reset = 1'b1;
        zoom_d    = bus.zoom_req;
        alg_d     = bus.alg_req;
        clr_start = 1'b1;
        pend_d    = 1'b0;
        run_to_d  = 1'b0;
        state_d   = S_CLEAR;
      end
      S_CLEAR: begin
        alu_reset  = 1'b1;
        ram_wren   = 1'b1;
        ram_wraddr = clr_addr;
        ram_data   = CLEAR_COLOR;
        clr_en     = 1'b1;
        if (clr_last) begin
          tcnt_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        alu_reset = 1'b1;
        if (tcnt_q == c_START_LAST) begin
          tcnt_d  = '0;
          state_d = S_COPY;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_COPY: begin
        ram_wren   = bus.alu_wren;
        ram_wraddr = bus.alu_wraddr;
        ram_data   = bus.alu_wrdata;
        tcnt_d     = tcnt_q + 1'b1;
        // tcnt_q==0 marks the first COPY cycle, where alu_done may still
        // be a stale level from the previous run.
        if (bus.alu_done && tcnt_q != '0) begin
          state_d = S_DONE;
        end else if (tcnt_q == c_TO_LAST) begin
          terr_d   = 1'b1;
          run_to_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!run_to_q) begin
          ucnt_d = ucnt_q + 1'b1;
        end
        if (cfg_change || pend_q || bus.refresh) begin
          state_d = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (cfg_change || bus.refresh) begin
          state_d = S_LATCH;
        end
      end
      default: begin
        state_d = S_LATCH;
      end
    endcase
  end

  assign bus.alu_reset    = alu_reset;
  assign bus.alu_zoom     = zoom_q;
  assign bus.alu_alg      = alg_q;
  assign bus.ram_wraddr   = ram_wraddr;
  assign bus.ram_data     = ram_data;
  assign bus.ram_wren     = ram_wren;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.timeout_err  = terr_q;
  assign bus.update_count = ucnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_update_scheduler
//  Description : Scoreboard bench for fb_update_scheduler. The driver walks
//                each rebuild with a phase-timing model (1 latch cycle,
//                FB_PIX clear cycles, START_CYC start cycles, then copy) and
//                queues the RAM writes and end-of-rebuild status it expects;
//                a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fb_update_scheduler;

  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 8;
  localparam int FB_PIX    = 16;
  localparam int START_CYC = 2;
  localparam int TO_CYC    = 32;
  localparam logic [7:0] CLR = 8'h00;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fb_update_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_update_scheduler #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .FB_PIXELS      (FB_PIX),
    .CLEAR_COLOR    (CLR),
    .START_CYCLES   (START_CYC),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [2:0]        z;
    logic [3:0]        a;
  } wr_t;

  typedef struct packed {
    logic [7:0] cnt;
    logic       terr;
    logic [2:0] z;
    logic [3:0] a;
  } st_t;

  wr_t wr_q[$];
  st_t st_q[$];
  wr_t e_wr;
  st_t e_st;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [2:0] m_z;
  logic [3:0] m_a;
  logic       m_pend;
  logic [7:0] m_cnt;
  logic       m_terr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_busy = 1'b1;
  always @(negedge clock) begin
    if (reset) begin
      prev_busy = 1'b1;
    end else begin
      if (bus.ram_wren) begin
        if (wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected (t=%0t)",
                   bus.ram_wraddr, bus.ram_data, $time);
        end else begin
          e_wr = wr_q.pop_front();
          check("ram_wraddr", 32'(bus.ram_wraddr), 32'(e_wr.addr));
          check("ram_data",   32'(bus.ram_data),   32'(e_wr.data));
          check("alu_zoom",   32'(bus.alu_zoom),   32'(e_wr.z));
          check("alu_alg",    32'(bus.alu_alg),    32'(e_wr.a));
        end
      end
      if (prev_busy && !bus.busy) begin
        if (st_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_idle: busy dropped with no rebuild expected to end (t=%0t)", $time);
        end else begin
          e_st = st_q.pop_front();
          check("update_count",    32'(bus.update_count), 32'(e_st.cnt));
          check("timeout_err",     32'(bus.timeout_err),  32'(e_st.terr));
          check("idle_alu_zoom",   32'(bus.alu_zoom),     32'(e_st.z));
          check("idle_alu_alg",    32'(bus.alu_alg),      32'(e_st.a));
          check("idle_ram_wraddr", 32'(bus.ram_wraddr),   32'd0);
          check("idle_alu_reset",  32'(bus.alu_reset),    32'd0);
        end
      end
      prev_busy = bus.busy;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic junk_alu();
    bus.alu_wren   = 1'($urandom_range(0, 1));
    bus.alu_wraddr = ADDR_W'($urandom);
    bus.alu_wrdata = 8'($urandom);
  endtask

  // Called at the start of a LATCH cycle. done_at<0 means the ALU never
  // finishes (timeout). chg_mode: 0 none, 1 zoom change, 2 zoom change and
  // revert, 3 alg change, all during COPY.
  task automatic do_run(input int done_at, input int chg_mode, input bit fixed_first,
                        output bit rerun);
    bit timed;
    bit fin;
    logic [2:0] orig_z;
    m_z = bus.zoom_req;
    m_a = bus.alg_req;
    m_pend = 1'b0;
    for (int i = 0; i < FB_PIX; i++) begin
      wr_q.push_back('{addr: ADDR_W'(i), data: CLR, z: m_z, a: m_a});
    end
    bus.refresh  = 1'b0;
    bus.alu_done = 1'b0;
    junk_alu();
    tick();
    // clear sweep
    for (int i = 0; i < FB_PIX; i++) begin
      check("alu_reset_clear", 32'(bus.alu_reset), 32'd1);
      junk_alu();
      bus.alu_done = 1'($urandom_range(0, 1));
      bus.refresh  = ($urandom_range(0, 127) == 0);
      if (bus.refresh) m_pend = 1'b1;
      tick();
    end
    // ALU restart pulse
    for (int i = 0; i < START_CYC; i++) begin
      junk_alu();
      bus.alu_wren = 1'b1;
      bus.refresh  = ($urandom_range(0, 127) == 0);
      if (bus.refresh) m_pend = 1'b1;
      #1;
      check("alu_reset_start", 32'(bus.alu_reset), 32'd1);
      check("ram_wren_start",  32'(bus.ram_wren),  32'd0);
      tick();
    end
    // copy
    timed  = 1'b0;
    fin    = 1'b0;
    orig_z = m_z;
    for (int k = 0; !fin; k++) begin
      junk_alu();
      if (fixed_first && k == 0) begin
        bus.alu_wren   = 1'b1;
        bus.alu_wraddr = ADDR_W'(5);
        bus.alu_wrdata = 8'hAA;
      end
      if (bus.alu_wren) begin
        wr_q.push_back('{addr: bus.alu_wraddr, data: bus.alu_wrdata, z: m_z, a: m_a});
      end
      bus.alu_done = (k == done_at) || (k == 0 && $urandom_range(0, 1) == 1);
      bus.refresh  = ($urandom_range(0, 127) == 0);
      if (bus.refresh) m_pend = 1'b1;
      if (chg_mode == 1 && k == 2) bus.zoom_req = 3'((int'(orig_z) + 1) % 5);
      if (chg_mode == 2 && k == 2) bus.zoom_req = 3'((int'(orig_z) + 2) % 5);
      if (chg_mode == 2 && k == 4) bus.zoom_req = orig_z;
      if (chg_mode == 3 && k == 3) bus.alg_req  = m_a + 4'd1;
      #1;
      check("alu_reset_copy", 32'(bus.alu_reset), 32'd0);
      if (k >= 1 && bus.alu_done) begin
        fin = 1'b1;
      end else if (k == TO_CYC - 1) begin
        fin   = 1'b1;
        timed = 1'b1;
      end
      tick();
    end
    // done cycle
    bus.alu_done = 1'b0;
    bus.refresh  = 1'b0;
    junk_alu();
    bus.alu_wren = 1'b1;
    #1;
    check("ram_wren_done", 32'(bus.ram_wren), 32'd0);
    if (timed) m_terr = 1'b1;
    else       m_cnt  = m_cnt + 8'd1;
    rerun = m_pend || ({bus.zoom_req, bus.alg_req} != {m_z, m_a});
    if (!rerun) st_q.push_back('{cnt: m_cnt, terr: m_terr, z: m_z, a: m_a});
    tick();
  endtask

  task automatic run_all(input int done_at, input int chg_mode, input bit fixed_first);
    bit rr;
    int guard;
    guard = 0;
    do_run(done_at, chg_mode, fixed_first, rr);
    while (rr) begin
      guard++;
      if (guard > 20) begin
        $display("FAIL rerun_guard: model expected more than 20 back-to-back rebuilds");
        $fatal(1, "rerun guard expired");
      end
      do_run($urandom_range(5, 20), 0, 1'b0, rr);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      junk_alu();
      bus.alu_wren = 1'b1;
      #1;
      check("ram_wren_idle", 32'(bus.ram_wren), 32'd0);
      check("busy_idle",     32'(bus.busy),     32'd0);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int trig;
    int dsel;
    bus.zoom_req   = 3'b010;
    bus.alg_req    = 4'h7;
    bus.refresh    = 1'b0;
    bus.alu_done   = 1'b0;
    bus.alu_wren   = 1'b0;
    bus.alu_wraddr = '0;
    bus.alu_wrdata = '0;
    m_cnt  = 8'd0;
    m_terr = 1'b0;

    #2 reset = 1'b1;
    #1;
    check("rst_alu_reset",    32'(bus.alu_reset),    32'd1);
    check("rst_ram_wren",     32'(bus.ram_wren),     32'd0);
    check("rst_busy",         32'(bus.busy),         32'd1);
    check("rst_update_count", 32'(bus.update_count), 32'd0);
    check("rst_timeout_err",  32'(bus.timeout_err),  32'd0);
    check("rst_alu_zoom",     32'(bus.alu_zoom),     32'd0);
    check("rst_alu_alg",      32'(bus.alu_alg),      32'd0);
    repeat (3) @(posedge clock);
    #1;
    bus.zoom_req = 3'b000;
    bus.alg_req  = 4'h0;
    reset = 1'b0;

    // power-up rebuild with a fixed pass-through write
    run_all(10, 0, 1'b1);
    idle_cycles(3);

    // zoom change in IDLE
    bus.zoom_req = 3'b001;
    tick();
    run_all(8, 0, 1'b0);
    idle_cycles(2);

    // zoom change during COPY -> rerun with new zoom
    bus.refresh = 1'b1;
    tick();
    run_all(8, 1, 1'b0);
    idle_cycles(2);

    // change then revert during COPY -> no rerun from the request
    bus.refresh = 1'b1;
    tick();
    run_all(8, 2, 1'b0);
    idle_cycles(2);

    // timeout, then a refresh-triggered rebuild
    bus.refresh = 1'b1;
    tick();
    run_all(-1, 0, 1'b0);
    idle_cycles(2);
    bus.refresh = 1'b1;
    tick();
    run_all(6, 0, 1'b0);
    idle_cycles(2);

    // randomized rebuilds
    for (int n = 0; n < 14; n++) begin
      trig = $urandom_range(0, 2);
      if (trig == 0) bus.refresh = 1'b1;
      else if (trig == 1) bus.zoom_req = 3'((int'(bus.zoom_req) + $urandom_range(1, 4)) % 5);
      else bus.alg_req = bus.alg_req + 4'(1 + $urandom_range(0, 14));
      tick();
      bus.refresh = 1'b0;
      dsel = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(5, 20);
      run_all(dsel, $urandom_range(0, 3), 1'b0);
      idle_cycles($urandom_range(1, 3));
    end

    // reset in the middle of the clear sweep (at address 7)
    bus.refresh = 1'b1;
    tick();
    bus.refresh = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_q.push_back('{addr: ADDR_W'(i), data: CLR, z: bus.zoom_req, a: bus.alg_req});
    end
    tick();
    repeat (7) tick();
    reset = 1'b1;
    #1;
    check("midclr_ram_wren",     32'(bus.ram_wren),     32'd0);
    check("midclr_busy",         32'(bus.busy),         32'd1);
    check("midclr_alu_reset",    32'(bus.alu_reset),    32'd1);
    check("midclr_update_count", 32'(bus.update_count), 32'd0);
    check("midclr_timeout_err",  32'(bus.timeout_err),  32'd0);
    check("midclr_alu_zoom",     32'(bus.alu_zoom),     32'd0);
    m_cnt  = 8'd0;
    m_terr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    run_all(9, 0, 1'b0);
    idle_cycles(3);

    check("write_queue_drained",  32'(wr_q.size()), 32'd0);
    check("status_queue_drained", 32'(st_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
